// File: rtl/date_pkg.sv
// Shared widths, result codes, FSM encoding and month-length table for the date checker.
package date_pkg;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int DOY_W   = 9;

  localparam logic [1:0] ERR_OK           = 2'd0;
  localparam logic [1:0] ERR_BAD_DATE     = 2'd1;
  localparam logic [1:0] ERR_OUT_OF_ORDER = 2'd2;

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, OUT} state_t;

  // Non-leap lengths, element 0 = January.
  localparam logic [11:0][DAY_W-1:0] MONTH_LEN = {
    5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
    5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
  };
endpackage

// File: rtl/month_len_rom.sv
// Month number to day count; 0 for any month outside 1..12.
module month_len_rom
  import date_pkg::*;
#(
  parameter int unsigned LEAP = 0
) (
  input  logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   len
);
  always_comb begin
    len = '0;
    if (month >= MONTH_W'(1) && month <= MONTH_W'(12)) begin
      len = MONTH_LEN[month - MONTH_W'(1)];
      if (LEAP != 0 && month == MONTH_W'(2)) len = DAY_W'(29);
    end
  end
endmodule

// File: rtl/date_order_checker.sv
// Validates (month, day), accumulates day-of-year one month per cycle,
// and flags dates earlier than the last accepted one.
module date_order_checker
  import date_pkg::*;
#(
  parameter int unsigned LEAP = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MONTH_W-1:0] in_month,
  input  logic [DAY_W-1:0]   in_day,
  output logic               out_valid,
  output logic [1:0]         out_err,
  output logic [DOY_W-1:0]   out_doy
);
  state_t             state, state_n;
  logic [MONTH_W-1:0] month_q, cnt, cnt_n;
  logic [DAY_W-1:0]   day_q, chk_len, acc_len;
  logic [DOY_W-1:0]   acc, acc_n, last_doy;
  logic               has_last, fin, bad, ooo;

  month_len_rom #(.LEAP(LEAP)) u_chk_rom (.month(month_q), .len(chk_len));
  month_len_rom #(.LEAP(LEAP)) u_acc_rom (.month(cnt),     .len(acc_len));

  assign in_ready = (state == IDLE);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    fin     = 1'b0;
    bad     = 1'b0;
    case (state)
      IDLE: if (in_valid) state_n = CHECK;
      CHECK: begin
        // chk_len is 0 for an illegal month, so any day fails the range test.
        if (day_q == '0 || day_q > chk_len) begin
          bad     = 1'b1;
          state_n = OUT;
        end else begin
          acc_n = DOY_W'(day_q);
          cnt_n = MONTH_W'(1);
          if (month_q == MONTH_W'(1)) begin
            fin     = 1'b1;
            state_n = OUT;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        acc_n = acc + DOY_W'(acc_len);
        cnt_n = cnt + MONTH_W'(1);
        if (cnt + MONTH_W'(1) == month_q) begin
          fin     = 1'b1;
          state_n = OUT;
        end
      end
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ooo = has_last && (acc_n < last_doy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      month_q   <= '0;
      day_q     <= '0;
      acc       <= '0;
      cnt       <= '0;
      has_last  <= 1'b0;
      last_doy  <= '0;
      out_valid <= 1'b0;
      out_err   <= ERR_OK;
      out_doy   <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= 1'b0;
      out_err   <= ERR_OK;
      out_doy   <= '0;
      if (state == IDLE && in_valid) begin
        month_q <= in_month;
        day_q   <= in_day;
      end
      if (bad) begin
        out_valid <= 1'b1;
        out_err   <= ERR_BAD_DATE;
      end
      if (fin) begin
        out_valid <= 1'b1;
        out_doy   <= acc_n;
        if (ooo) begin
          out_err <= ERR_OUT_OF_ORDER;
        end else begin
          out_err  <= ERR_OK;
          last_doy <= acc_n;
          has_last <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_date_order_checker.sv
// Directed bench: one non-leap and one leap instance sharing clock and reset.
module tb_date_order_checker;
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           iv, ir, ov;
  logic [1:0][3:0]      im;
  logic [1:0][4:0]      id;
  logic [1:0][1:0]      oe;
  logic [1:0][8:0]      od;
  int                   tests = 0;
  int                   fails = 0;

  always #5 clk = ~clk;

  date_order_checker #(.LEAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_month(im[0]), .in_day(id[0]), .out_valid(ov[0]), .out_err(oe[0]), .out_doy(od[0]));
  date_order_checker #(.LEAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_month(im[1]), .in_day(id[1]), .out_valid(ov[1]), .out_err(oe[1]), .out_doy(od[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Transfer one date and follow it to its result; hold keeps in_valid high with noise data.
  task automatic send(input int u, input int m, input int d, input int eerr,
                      input int edoy, input int elat, input bit hold, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " ready"}, int'(ir[u]), 1);
    iv[u] = 1'b1; im[u] = 4'(m); id[u] = 5'(d);
    @(posedge clk); #1;
    if (!hold) iv[u] = 1'b0;
    n = 0;
    while (!ov[u] && n < 40) begin
      chk({tag, " busy"}, int'(ir[u]), 0);
      chk({tag, " idle_out"}, int'({oe[u], od[u]}), 0);
      if (hold) begin
        im[u] = 4'($urandom_range(1, 12)); id[u] = 5'($urandom_range(1, 28));
      end
      @(posedge clk); #1;
      n++;
    end
    iv[u] = 1'b0;
    chk({tag, " latency"}, n + 1, elat);
    chk({tag, " err"}, int'(oe[u]), eerr);
    chk({tag, " doy"}, int'(od[u]), edoy);
    @(posedge clk); #1;
    chk({tag, " post_valid"}, int'(ov[u]), 0);
    chk({tag, " post_ready"}, int'(ir[u]), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int seen;
    iv = '0; im = '0; id = '0;
    #12;
    chk("rst ready", int'(ir[0]), 1);
    chk("rst valid", int'(ov[0]), 0);
    chk("rst err", int'(oe[0]), 0);
    chk("rst doy", int'(od[0]), 0);
    rst_n = 1'b1;

    send(0, 1, 1, 0, 1, 2, 1'b0, "jan1");
    send(0, 12, 31, 0, 365, 13, 1'b0, "dec31");

    do_reset();
    send(0, 2, 29, 1, 0, 2, 1'b0, "feb29_nonleap");
    send(0, 2, 28, 0, 59, 3, 1'b0, "feb28");
    send(0, 0, 5, 1, 0, 2, 1'b0, "month0");
    send(0, 13, 1, 1, 0, 2, 1'b0, "month13");
    send(0, 4, 31, 1, 0, 2, 1'b0, "apr31");
    send(0, 6, 0, 1, 0, 2, 1'b0, "day0");
    send(0, 2, 27, 2, 58, 3, 1'b0, "after_bad_ooo");
    send(0, 3, 1, 0, 60, 4, 1'b0, "mar1");
    send(0, 2, 10, 2, 41, 3, 1'b0, "feb10_ooo");
    send(0, 3, 1, 0, 60, 4, 1'b0, "mar1_equal");
    send(0, 3, 2, 0, 61, 4, 1'b0, "mar2");
    send(0, 5, 10, 0, 130, 6, 1'b1, "hold_may10");

    // Abort a December date mid-accumulation.
    @(negedge clk);
    iv[0] = 1'b1; im[0] = 4'd12; id[0] = 5'd31;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst valid", int'(ov[0]), 0);
    chk("midrst ready", int'(ir[0]), 1);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (ov[0]) seen++;
    end
    chk("midrst no_result", seen, 0);
    send(0, 1, 5, 0, 5, 2, 1'b0, "jan5_after_rst");

    send(1, 2, 29, 0, 60, 3, 1'b0, "leap_feb29");
    send(1, 12, 31, 0, 366, 13, 1'b0, "leap_dec31");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/date_order_checker.md
Name: date_order_checker

Overview:
- Consumes the per-month day-validity table data and validates a stream of calendar dates (month, day) arriving over a valid/ready handshake.
- Computes the day-of-year serially, accumulating one month length per cycle.
- Flags dates that precede the last accepted date.
- Sits directly downstream of the date-matrix table and feeds the transaction-ordering logic.

Parameters:
- LEAP, 0, 1 makes February 29 days long (and December 31 = day 366); 0 makes it 28 days.
- MONTH_W, 4, month field width.
- DAY_W, 5, day field width.
- DOY_W, 9, day-of-year width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  date present on in_month/in_day.
- in_ready  output  1  block can accept a date.
- in_month  input  MONTH_W  month, legal 1..12.
- in_day  input  DAY_W  day, legal 1..month length.
- out_valid  output  1  single-cycle result strobe.
- out_err  output  2  0 = OK, 1 = BAD_DATE, 2 = OUT_OF_ORDER.
- out_doy  output  DOY_W  day-of-year, 1..365 (366 if LEAP).

Behaviour:
- Reset is asynchronous: while rst_n is low, every register clears.
  - state = IDLE, in_ready = 1, out_valid = 0, out_err = 0, out_doy = 0, has_last = 0, last_doy = 0.
  - Reset during any state aborts the operation; no out_valid is produced for it.
- A transfer happens on a rising edge with in_valid & in_ready. The edge on which this occurs is edge T.
  - in_month/in_day are registered at T.
  - in_ready is 0 from T until the cycle after OUT. Any in_valid seen while in_ready is 0 is ignored.
- FSM states and transitions:
  - IDLE: in_ready = 1. Goes to CHECK on a transfer.
  - CHECK (one cycle): the date is legal if month is 1..12 and 1 <= day <= len(month).
    - Illegal date: err = BAD_DATE, doy = 0, go to OUT.
    - Legal date: acc = day, cnt = 1. Go to OUT if month == 1, otherwise go to ACCUM.
  - ACCUM: each cycle does acc += len(cnt) and cnt += 1. After the cycle that adds len(month-1), go to OUT. ACCUM therefore lasts exactly month-1 cycles.
  - OUT (one cycle): out_valid = 1, with out_err and out_doy driven from registers; next state is IDLE.
- Month lengths: 31,28,31,30,31,30,31,31,30,31,30,31. February is 29 when LEAP = 1.
- Ordering check, evaluated on entry to OUT for legal dates:
  - If has_last = 1 and acc < last_doy: err = OUT_OF_ORDER, out_doy = acc, last_doy unchanged.
  - Otherwise: err = OK, last_doy = acc, has_last = 1.
  - An equal date is OK.
  - The first legal date after reset is always OK.
- A BAD_DATE result never updates last_doy or has_last.
- Latency from T to the out_valid cycle:
  - Illegal date: 2 cycles.
  - Legal date: month+1 cycles (January = 2, December = 13).
- out_err and out_doy are 0 in every cycle where out_valid = 0.
- The accumulator is DOY_W bits wide. The maximum value 366 fits, so no overflow handling is needed.
- Back-to-back operation: in_ready rises in the IDLE cycle after OUT. The next transfer can therefore occur on the edge ending that IDLE cycle, giving a minimum spacing of latency+1 cycles.

Decomposition:
- Shared package date_pkg holds:
  - Width constants MONTH_W, DAY_W, DOY_W.
  - Error-code constants ERR_OK / ERR_BAD_DATE / ERR_OUT_OF_ORDER.
  - The FSM state encoding IDLE/CHECK/ACCUM/OUT.
  - The non-leap month-length constant array.
- Sub-module month_len_rom: combinational, month in, length out (0 for an illegal month), LEAP parameter.
  - Two instances: one for the validity check, one for the accumulation index cnt. Alternatively a single instance muxed by state.

Test Plan:
- Reset, then (1,1) → out_valid 2 cycles after T, err 0, doy 1; then (12,31) → latency 13, err 0, doy 365.
- LEAP=0, (2,29) → latency 2, err 1, doy 0; a following (2,28) → err 0, doy 59, showing last_doy was not disturbed.
- Illegal fields (0,5), (13,1), (4,31), (6,0) → each err 1, latency 2, has_last unchanged.
- Ordering sequence (3,1)=60 OK, (2,10)=41 → err 2 with doy 41, (3,1) equal → OK, (3,2)=61 → OK.
- in_valid held high with changing data during ACCUM → ignored, exactly one result per accepted date; assert rst_n low mid-ACCUM for one cycle → no out_valid, and the next date (1,5) is OK with doy 5 even if earlier than the pre-reset date.
- LEAP=1: (2,29) → OK, doy 60; (12,31) → doy 366.
